// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// Stage entries are laid out {valid, data, ctrl}, MSB first, at the instantiating module's widths.
package pipe_stage_pkg;

    typedef logic [1:0] occupancy_t;

    localparam occupancy_t OCC_EMPTY = 2'd0;
    localparam occupancy_t OCC_FULL  = 2'd2;

    function automatic occupancy_t occ_count(input logic m_valid, input logic s_valid);
        return occupancy_t'({1'b0, m_valid}) + occupancy_t'({1'b0, s_valid});
    endfunction

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating performance counters for the elastic pipeline stage (stall, bubble, flush cycles).
// Instantiated only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf #(
    parameter int unsigned CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            out_valid_i,
    input  logic            out_ready_i,
    output logic [CntW-1:0] stall_cnt_o,
    output logic [CntW-1:0] bubble_cnt_o,
    output logic [CntW-1:0] flush_cnt_o
);

    logic [CntW-1:0] stall_q, stall_d;
    logic [CntW-1:0] bubble_q, bubble_d;
    logic [CntW-1:0] flush_q, flush_d;

    // Each counter sticks at all-ones once it gets there.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (out_valid_i && !out_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + CntW'(1);
        end
        if (!out_valid_i && (bubble_q != '1)) begin
            bubble_d = bubble_q + CntW'(1);
        end
        if (flush_i && (flush_q != '1)) begin
            flush_d = flush_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
    assign flush_cnt_o  = flush_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// One-clock valid/ready pipeline stage with a 2-entry skid buffer, flush and bubble ctrl zeroing.
// Define PIPE_STAGE_PERF_EN to add the stall/bubble/flush counter ports.
module pipe_stage_elastic
    import pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CTRL_W      = 16,
    parameter bit          ZERO_BUBBLE = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output occupancy_t        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } stage_entry_t;

    stage_entry_t m_q, m_d;
    stage_entry_t s_q, s_d;
    logic         accept;
    logic         drain;

    // S only fills while M is valid, so !S.valid alone decides whether a slot is free.
    assign in_ready = ~s_q.valid;
    assign accept   = in_valid & in_ready;
    assign drain    = m_q.valid & out_ready;

    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (!m_q.valid || drain) begin
            if (s_q.valid) begin
                m_d       = s_q;
                s_d.valid = 1'b0;
            end else begin
                m_d.valid = accept;
                if (accept) begin
                    m_d.data = in_data;
                    m_d.ctrl = in_ctrl;
                end
            end
        end else if (accept) begin
            s_d.valid = 1'b1;
            s_d.data  = in_data;
            s_d.ctrl  = in_ctrl;
        end
        if (flush) begin
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign out_valid = m_q.valid;
    assign out_data  = m_q.data;
    assign out_ctrl  = (ZERO_BUBBLE && !m_q.valid) ? '0 : m_q.ctrl;
    assign occupancy = occ_count(m_q.valid, s_q.valid);

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf #(
        .CntW (CNT_W)
    ) u_perf (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .out_valid_i  (m_q.valid),
        .out_ready_i  (out_ready),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt),
        .flush_cnt_o  (flush_cnt)
    );
`else
    // CNT_W only sizes the counters; a zero width is never a sensible build.
    if (CNT_W == 0) begin : g_cnt_w_zero
    end
`endif

endmodule
